// File: rtl/iter_right_shifter.sv
// Multi-cycle right shifter: walks a 5-bit shift amount down in steps of 4 and 1,
// one step per clock, with zero-fill or sign-fill and a start/busy/done handshake.
module iter_right_shifter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [4:0]       shamt,
  input  logic             arith,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] work, work_n;
  logic [4:0]       cnt, cnt_n;
  logic             fill, fill_n;
  logic [WIDTH-1:0] result_n;
  logic             busy_n, done_n;

  function automatic logic [WIDTH-1:0] shr4(input logic [WIDTH-1:0] v, input logic f);
    return {{4{f}}, v[WIDTH-1:4]};
  endfunction

  function automatic logic [WIDTH-1:0] shr1(input logic [WIDTH-1:0] v, input logic f);
    return {f, v[WIDTH-1:1]};
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      work   <= '0;
      cnt    <= '0;
      fill   <= 1'b0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      work   <= work_n;
      cnt    <= cnt_n;
      fill   <= fill_n;
      result <= result_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    work_n   = work;
    cnt_n    = cnt;
    fill_n   = fill;
    result_n = result;
    busy_n   = busy;
    done_n   = 1'b0;
    unique case (state)
      IDLE: begin
        // Operands are captured only here; later input changes cannot leak in.
        if (start) begin
          work_n  = A;
          cnt_n   = shamt;
          fill_n  = arith & A[WIDTH-1];
          busy_n  = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt >= 5'd4) begin
          work_n = shr4(work, fill);
          cnt_n  = cnt - 5'd4;
        end else if (cnt != 5'd0) begin
          work_n = shr1(work, fill);
          cnt_n  = cnt - 5'd1;
        end else begin
          result_n = work;
          done_n   = 1'b1;
          busy_n   = 1'b0;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_iter_right_shifter.sv
// Bench for iter_right_shifter: table vectors, handshake corner sequences and
// randomized operations checked against an arithmetic reference model.
module tb_iter_right_shifter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] A;
  logic [4:0]  shamt;
  logic        arith;
  logic [31:0] result;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  iter_right_shifter #(.WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .A(A), .shamt(shamt),
    .arith(arith), .result(result), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  sh;
    logic        ar;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_res(input logic [31:0] a, input logic [4:0] sh, input logic ar);
    logic signed [31:0] sa;
    logic [31:0] r;
    sa = a;
    if (ar) r = sa >>> sh;
    else    r = a >> sh;
    return r;
  endfunction

  function automatic int model_lat(input logic [4:0] sh);
    return int'(sh) / 4 + int'(sh) % 4 + 1;
  endfunction

  // One complete operation: accept, count edges to done, check result and handshake.
  task automatic do_op(input logic [31:0] a, input logic [4:0] sh, input logic ar,
                       input logic [31:0] exp_res, input int exp_lat, input string nm);
    int edges;
    bit got, busy_ok, overlap;
    logic [31:0] prev;
    prev = result;
    @(negedge clock);
    A = a; shamt = sh; arith = ar; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    A = $urandom; shamt = 5'($urandom); arith = 1'($urandom);
    busy_ok = busy; overlap = 1'b0;
    edges = 0; got = 1'b0;
    while (!got && edges < 20) begin
      if (!got && result !== prev) overlap = 1'b1;
      @(posedge clock); #1;
      edges++;
      if (done) got = 1'b1;
      else if (!busy) busy_ok = 1'b0;
      if (done && busy) overlap = 1'b1;
    end
    chk({nm, "_done_seen"}, 32'(got), 32'd1);
    chk({nm, "_latency"}, 32'(edges), 32'(exp_lat));
    chk({nm, "_result"}, result, exp_res);
    chk({nm, "_busy_hold"}, 32'({busy_ok, busy}), 32'b10);
    chk({nm, "_no_overlap"}, 32'(overlap), 32'd0);
    @(posedge clock); #1;
    chk({nm, "_done_pulse"}, 32'(done), 32'd0);
    chk({nm, "_result_held"}, result, exp_res);
  endtask

  vec_t vecs[6];

  initial begin
    int ndone, done_cyc;
    bit bad;
    logic [31:0] ra;
    logic [4:0]  rs;
    logic        rar;

    vecs[0] = '{32'h80000000, 5'd4,  1'b0, 32'h08000000, 2};
    vecs[1] = '{32'h80000000, 5'd4,  1'b1, 32'hF8000000, 2};
    vecs[2] = '{32'h80000000, 5'd31, 1'b1, 32'hFFFFFFFF, 11};
    vecs[3] = '{32'hFFFFFFFF, 5'd31, 1'b0, 32'h00000001, 11};
    vecs[4] = '{32'h12345678, 5'd0,  1'b0, 32'h12345678, 1};
    vecs[5] = '{32'h7FFF0000, 5'd8,  1'b1, 32'h007FFF00, 3};

    reset_n = 1'b0; start = 1'b0; A = '0; shamt = '0; arith = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_result", result, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clock); reset_n = 1'b1;

    foreach (vecs[i])
      do_op(vecs[i].a, vecs[i].sh, vecs[i].ar, vecs[i].exp_res, vecs[i].exp_lat,
            $sformatf("vec%0d", i));

    // Starts on edge 2 and on the done edge 5 must be ignored.
    @(negedge clock);
    A = 32'hDEADBEEF; shamt = 5'd7; arith = 1'b0; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    ndone = 0; done_cyc = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clock);
      if (k == 2 || k == 5) begin start = 1'b1; A = 32'h0F0F0F0F; shamt = 5'd3; end
      else start = 1'b0;
      @(posedge clock); #1;
      if (done) begin ndone++; done_cyc = k; end
    end
    start = 1'b0;
    chk("ign_done_count", 32'(ndone), 32'd1);
    chk("ign_done_edge", 32'(done_cyc), 32'd5);
    chk("ign_result", result, 32'h01BD5B7D);
    chk("ign_idle", 32'(busy), 32'd0);

    // Start held high: accept, shift, done, repeat every third edge.
    @(negedge clock);
    A = 32'h00000002; shamt = 5'd1; arith = 1'b0; start = 1'b1;
    bad = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clock); #1;
      chk($sformatf("b2b_done_e%0d", k), 32'(done), 32'((k % 3) == 0));
      if (done && busy) bad = 1'b1;
      if (done && result !== 32'h1) bad = 1'b1;
    end
    @(negedge clock); start = 1'b0;
    chk("b2b_overlap_or_result", 32'(bad), 32'd0);
    repeat (3) @(posedge clock);

    // Asynchronous abort in the middle of a 20-bit shift.
    @(negedge clock);
    A = 32'hA5A5A5A5; shamt = 5'd20; arith = 1'b1; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    repeat (3) @(posedge clock);
    #2; reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", result, 32'h0);
    @(negedge clock); reset_n = 1'b1;
    ndone = 0;
    repeat (15) begin @(posedge clock); #1; if (done) ndone++; end
    chk("abort_no_done", 32'(ndone), 32'd0);
    do_op(32'hC0000001, 5'd5, 1'b1, 32'hFE000000, 3, "post_abort");

    for (int n = 0; n < 40; n++) begin
      ra = $urandom; rs = 5'($urandom); rar = 1'($urandom);
      if (n % 8 == 0) rs = 5'd31;
      if (n % 8 == 1) rs = 5'd0;
      do_op(ra, rs, rar, model_res(ra, rs, rar), model_lat(rs), $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
